// File: rtl/serial_port_router_pkg.sv
// Shared types and defaults for the serial port router.
// Optional feature macro: SERIAL_ROUTER_PARITY_EN (adds the PAR state).
package serial_router_pkg;

    localparam int unsigned DEF_PORT_W = 2;
    localparam int unsigned DEF_LEN_W  = 4;

    // Line idles high; a low sample in IDLE opens a frame.
    localparam logic START_BIT = 1'b0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PORT,
        S_LEN,
        S_DATA,
`ifdef SERIAL_ROUTER_PARITY_EN
        S_PAR,
`endif
        S_DONE
    } router_state_t;

endpackage

// File: rtl/serial_port_router_if.sv
// Serial line plus per-port outputs of the router.
interface serial_port_router_if #(
    parameter int unsigned PORT_W = 2
);
    localparam int unsigned NPORT = 2 ** PORT_W;

    logic             serIn;
    logic             serOut;
    logic [NPORT-1:0] serOutValid;
    logic             busy;
    logic             done;
    logic             parErr;

    // Line driver side.
    modport master (
        output serIn,
        input  serOut, serOutValid, busy, done, parErr
    );

    // Router side.
    modport slave (
        input  serIn,
        output serOut, serOutValid, busy, done, parErr
    );
endinterface

// File: rtl/serial_port_router_frame_down_counter.sv
// Loadable down-counter shared by the field phases and the payload phase.
module frame_down_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    // Load has priority over decrement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (ld) begin
            cnt_q <= d;
        end else if (en) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/serial_port_router.sv
// Frame sequencer: start bit, port address, length, then length+1 payload
// bits routed to the addressed port, closed by a one-cycle done.
// Optional feature macro: SERIAL_ROUTER_PARITY_EN (even parity bit after payload).
module serial_port_router
    import serial_router_pkg::*;
#(
    parameter int unsigned PORT_W = DEF_PORT_W,
    parameter int unsigned LEN_W  = DEF_LEN_W
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_port_router_if.slave  sif
);

    localparam int unsigned NPORT = 2 ** PORT_W;

    router_state_t     state_q, state_d;
    logic [PORT_W-1:0] port_q;
    logic [LEN_W-1:0]  len_q;

    logic              cnt_ld, cnt_en, cnt_zero;
    logic [LEN_W-1:0]  cnt_d;
    logic              port_sh, len_sh;

`ifdef SERIAL_ROUTER_PARITY_EN
    logic              par_q;
    logic              par_clr, par_acc;
`endif

    // One counter times the port field, the length field and the payload.
    frame_down_counter #(.W(LEN_W)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .ld   (cnt_ld),
        .en   (cnt_en),
        .d    (cnt_d),
        .zero (cnt_zero)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Field shift registers; they hold until the next frame's PORT phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            port_q <= '0;
            len_q  <= '0;
        end else begin
            if (port_sh) port_q <= PORT_W'({port_q, sif.serIn});
            if (len_sh)  len_q  <= LEN_W'({len_q, sif.serIn});
        end
    end

`ifdef SERIAL_ROUTER_PARITY_EN
    // Running XOR over payload and parity bit; non-zero means odd parity.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_q <= 1'b0;
        end else if (par_clr) begin
            par_q <= 1'b0;
        end else if (par_acc) begin
            par_q <= par_q ^ sif.serIn;
        end
    end
`endif

    // Next-state, counter control and Moore output decode.
    always_comb begin
        state_d         = state_q;
        cnt_ld          = 1'b0;
        cnt_en          = 1'b0;
        cnt_d           = '0;
        port_sh         = 1'b0;
        len_sh          = 1'b0;
`ifdef SERIAL_ROUTER_PARITY_EN
        par_clr         = 1'b0;
        par_acc         = 1'b0;
`endif
        sif.busy        = 1'b1;
        sif.done        = 1'b0;
        sif.parErr      = 1'b0;
        sif.serOut      = 1'b0;
        sif.serOutValid = '0;

        case (state_q)
            S_IDLE: begin
                sif.busy = 1'b0;
                if (sif.serIn == START_BIT) begin
                    state_d = S_PORT;
                    cnt_ld  = 1'b1;
                    cnt_d   = LEN_W'(PORT_W - 1);
`ifdef SERIAL_ROUTER_PARITY_EN
                    par_clr = 1'b1;
`endif
                end
            end
            S_PORT: begin
                port_sh = 1'b1;
                if (cnt_zero) begin
                    state_d = S_LEN;
                    cnt_ld  = 1'b1;
                    cnt_d   = LEN_W'(LEN_W - 1);
                end else begin
                    cnt_en = 1'b1;
                end
            end
            S_LEN: begin
                len_sh = 1'b1;
                if (cnt_zero) begin
                    state_d = S_DATA;
                    cnt_ld  = 1'b1;
                    // Completed length includes the bit arriving this edge.
                    cnt_d   = LEN_W'({len_q, sif.serIn});
                end else begin
                    cnt_en = 1'b1;
                end
            end
            S_DATA: begin
                sif.serOut      = sif.serIn;
                sif.serOutValid = NPORT'(1) << port_q;
`ifdef SERIAL_ROUTER_PARITY_EN
                par_acc = 1'b1;
`endif
                if (cnt_zero) begin
`ifdef SERIAL_ROUTER_PARITY_EN
                    state_d = S_PAR;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    cnt_en = 1'b1;
                end
            end
`ifdef SERIAL_ROUTER_PARITY_EN
            S_PAR: begin
                par_acc = 1'b1;
                state_d = S_DONE;
            end
`endif
            S_DONE: begin
                sif.done = 1'b1;
`ifdef SERIAL_ROUTER_PARITY_EN
                sif.parErr = par_q;
`endif
                // serIn is ignored here: a low bit is not a start bit.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_port_router.sv
// Scoreboard bench for serial_port_router (default PORT_W=2, LEN_W=4).
module tb_serial_port_router;

    typedef struct {
        logic [3:0] valid;
        logic       bit_v;
    } exp_beat_t;

    logic clk;
    logic rst;

    int checks;
    int errors;

    exp_beat_t exp_q[$];
    logic      done_q[$];

    serial_port_router_if #(.PORT_W(2)) sif ();

    serial_port_router #(.PORT_W(2), .LEN_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .sif (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Output monitor: payload beats and done pulses are matched against the queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (sif.serOutValid != 4'b0000) begin
                if (exp_q.size() == 0) begin
                    check("spurious_valid", 32'(sif.serOutValid), 32'd0);
                end else begin
                    exp_beat_t e;
                    e = exp_q.pop_front();
                    check("valid", 32'(sif.serOutValid), 32'(e.valid));
                    check("serout", 32'(sif.serOut), 32'(e.bit_v));
                end
            end
            if (sif.done) begin
                if (done_q.size() == 0) begin
                    check("spurious_done", 32'(sif.done), 32'd0);
                end else begin
                    logic pe;
                    pe = done_q.pop_front();
                    check("parerr", 32'(sif.parErr), 32'(pe));
                end
            end
        end
    end

    // Drive one bit right after an edge; the DUT samples it at the next edge.
    task automatic send_bit(input logic b);
        sif.serIn = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [1:0] port, input logic [3:0] len,
                              input logic [15:0] pl, input logic parbit,
                              input logic dbit);
        logic par;
        exp_beat_t e;
        par = 1'b0;
        send_bit(1'b0);
        for (int i = 1; i >= 0; i--) send_bit(port[i]);
        for (int i = 3; i >= 0; i--) send_bit(len[i]);
        for (int i = 0; i <= int'(len); i++) begin
            e.valid = 4'b0001 << port;
            e.bit_v = pl[i];
            exp_q.push_back(e);
            par = par ^ pl[i];
            send_bit(pl[i]);
        end
`ifdef SERIAL_ROUTER_PARITY_EN
        par = par ^ parbit;
        send_bit(parbit);
        done_q.push_back(par);
`else
        if (parbit) par = 1'b0;
        done_q.push_back(1'b0);
`endif
        // DONE cycle: done must be up exactly here, with the line at dbit.
        sif.serIn = dbit;
        @(negedge clk);
        check("done_timing", 32'(sif.done), 32'd1);
        check("done_busy", 32'(sif.busy), 32'd1);
        @(posedge clk);
        #1;
        sif.serIn = 1'b1;
    endtask

    initial begin
        exp_beat_t e;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        sif.serIn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(sif.busy), 32'd0);
        check("rst_valid", 32'(sif.serOutValid), 32'd0);
        check("rst_done", 32'(sif.done), 32'd0);
        check("rst_parerr", 32'(sif.parErr), 32'd0);
        check("rst_serout", 32'(sif.serOut), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Idle line: nothing happens.
        for (int i = 0; i < 20; i++) begin
            send_bit(1'b1);
            check("idle_busy", 32'(sif.busy), 32'd0);
        end

        // Frame to port 1, length 3, payload 1,0,1,1.
        send_frame(2'd1, 4'd3, 16'h000D, 1'b0, 1'b1);
        check("after_f1_busy", 32'(sif.busy), 32'd0);

        // Minimum payload to port 3.
        send_frame(2'd3, 4'd0, 16'h0001, 1'b0, 1'b1);

        // Maximum payload to port 0, low bit during DONE must not start a frame.
        send_frame(2'd0, 4'd15, 16'(($urandom() & 32'hFFFF)), 1'b0, 1'b0);
        check("done_low_ignored", 32'(sif.busy), 32'd0);
        send_bit(1'b1);
        check("still_idle", 32'(sif.busy), 32'd0);

        // Reset in the middle of DATA: frame to port 1, length 5.
        send_bit(1'b0);
        send_bit(1'b0); send_bit(1'b1);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        for (int i = 0; i < 2; i++) begin
            e.valid = 4'b0010;
            e.bit_v = 1'b1;
            exp_q.push_back(e);
            send_bit(1'b1);
        end
        rst = 1'b1;
        #1;
        check("midrst_valid", 32'(sif.serOutValid), 32'd0);
        check("midrst_busy", 32'(sif.busy), 32'd0);
        check("midrst_done", 32'(sif.done), 32'd0);
        check("midrst_serout", 32'(sif.serOut), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_bit(1'b1);

        // A following frame is routed normally.
        send_frame(2'd2, 4'd2, 16'h0005, 1'b0, 1'b1);

`ifdef SERIAL_ROUTER_PARITY_EN
        // Payload 1,1,0 with parity 1 is odd overall; with parity 0 it is even.
        send_frame(2'd2, 4'd2, 16'h0003, 1'b1, 1'b1);
        send_frame(2'd2, 4'd2, 16'h0003, 1'b0, 1'b1);
`endif

        repeat (3) send_bit(1'b1);
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        check("done_q_empty", 32'(done_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
